// File: rtl/if_fetch_queue_pkg.sv
// Shared pipeline definitions for the IF/ID boundary.
//   DATA_LEN      : default PC / instruction width
//   NOP_INSTR     : all-zero word that ID decodes as a bubble
//   fetch_entry_t : {pc, instr} pair, also used by the ID stage register
package if_fetch_queue_pkg;
  localparam int DATA_LEN = 32;
  localparam logic [DATA_LEN-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [DATA_LEN-1:0] pc;
    logic [DATA_LEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_queue_ctrl.sv
// Pointer / occupancy control for the IF->ID fetch queue.
//   clk, rst      : clock, async active-low reset
//   i_flush       : branch taken; clears pointers and count on the next edge
//   i_push_req    : IF presents a pair
//   i_pop_req     : ID takes the head entry
//   o_wr_ptr      : storage write index
//   o_rd_ptr      : storage read index (head)
//   o_count       : occupancy 0..DEPTH
//   o_full/o_empty: occupancy flags
//   o_push        : qualified push (storage write enable)
module fetch_queue_ctrl #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push_req,
  input  logic             i_pop_req,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [PTR_W:0]   o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_push
);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  // A full queue refuses IF even when ID pops in the same cycle; IF just
  // holds its PC and retries, which keeps the freeze path purely registered.
  assign w_push  = i_push_req & ~w_full  & ~i_flush;
  assign w_pop   = i_pop_req  & ~w_empty & ~i_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap through natural PTR_W overflow (DEPTH is a power of two).
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_push   = w_push;
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction prefetch queue between IF and ID.
//   clk, rst          : clock, async active-low reset
//   flush             : branch taken from EXE, empties the queue
//   if_valid/pc/instr : pair offered by IF
//   if_freeze         : back-pressure to IF (queue full)
//   id_ready          : ID consumes the head (low during hazard stall)
//   id_valid/pc/instr : head entry; pc/instr are zero (NOP) when empty
//   count             : occupancy 0..DEPTH
// DEPTH must be a power of two and at least 2.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DATA_LEN = if_fetch_queue_pkg::DATA_LEN,
  parameter int DEPTH    = 4,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_valid,
  input  logic [DATA_LEN-1:0] if_pc,
  input  logic [DATA_LEN-1:0] if_instr,
  output logic                if_freeze,
  input  logic                id_ready,
  output logic                id_valid,
  output logic [DATA_LEN-1:0] id_pc,
  output logic [DATA_LEN-1:0] id_instr,
  output logic [PTR_W:0]      count
);
  logic [PTR_W-1:0]      w_wr_ptr, w_rd_ptr;
  logic                  w_full, w_empty, w_push;
  logic [2*DATA_LEN-1:0] w_head;

  // Storage is not reset: contents are only visible through id_* while
  // occupancy says the slot is live.
  logic [DEPTH-1:0][2*DATA_LEN-1:0] r_mem;

  fetch_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_push_req (if_valid),
    .i_pop_req  (id_ready),
    .o_wr_ptr   (w_wr_ptr),
    .o_rd_ptr   (w_rd_ptr),
    .o_count    (count),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_push     (w_push)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_ptr] <= {if_pc, if_instr};
  end

  assign w_head    = r_mem[w_rd_ptr];
  assign if_freeze = w_full;
  assign id_valid  = ~w_empty;
  assign id_pc     = w_empty ? '0 : w_head[2*DATA_LEN-1:DATA_LEN];
  assign id_instr  = w_empty ? DATA_LEN'(NOP_INSTR) : w_head[DATA_LEN-1:0];
endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic                clk = 1'b0;
  logic                rst;
  logic                flush, if_valid, id_ready;
  logic [DATA_LEN-1:0] if_pc, if_instr;
  logic                if_freeze, id_valid;
  logic [DATA_LEN-1:0] id_pc, id_instr;
  logic [PTR_W:0]      count;

  if_fetch_queue #(.DATA_LEN(DATA_LEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_freeze (if_freeze),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  fetch_entry_t sb[$];     // entries expected at the ID side, oldest first
  bit           accepted;  // model: did the last offered pair get queued

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check 1ns later against the scoreboard,
  // then advance the model with the same inputs the DUT sees at the next posedge.
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit rdy, input bit fl);
    int n;
    fetch_entry_t e;
    @(negedge clk);
    if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl;
    #1;
    n = sb.size();
    chk("count",    64'(count),     64'(n));
    chk("id_valid", 64'(id_valid),  64'(n != 0));
    chk("freeze",   64'(if_freeze), 64'(n == DEPTH));
    if (n != 0) begin
      chk("head_pc",    64'(id_pc),    64'(sb[0].pc));
      chk("head_instr", 64'(id_instr), 64'(sb[0].instr));
    end else begin
      chk("nop_pc",    64'(id_pc),    64'(0));
      chk("nop_instr", 64'(id_instr), 64'(0));
    end
    accepted = 1'b0;
    if (fl) begin
      sb.delete();
    end else begin
      if (rdy && n != 0) void'(sb.pop_front());
      if (v && n != DEPTH) begin
        e.pc = pc; e.instr = ins;
        sb.push_back(e);
        accepted = 1'b1;
      end
    end
  endtask

  // Drain with ID ready and IF idle; bounded.
  task automatic drain();
    for (int k = 0; k < 3*DEPTH && sb.size() != 0; k++) cycle(0, 0, 0, 1, 0);
    chk("drained", 64'(sb.size()), 64'(0));
    cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] pc;
    int pushed;
    rst = 1'b0; flush = 0; if_valid = 0; id_ready = 0; if_pc = '0; if_instr = '0;

    // Reset state, with traffic attempted while held in reset.
    @(negedge clk);
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_valid", 64'(id_valid), 64'(0));
    chk("rst_freeze", 64'(if_freeze), 64'(0));
    @(negedge clk); rst = 1'b1;
    cycle(0, 0, 0, 0, 0);

    // Fill to full with ID stalled, then a 5th pair that must be refused.
    for (int i = 0; i < 4; i++) cycle(1, 32'(4*(i+1)), 32'hA000_0000 + 32'(i), 0, 0);
    cycle(1, 32'd20, 32'hA000_0004, 0, 0);
    chk("fifth_refused", 64'(accepted), 64'(0));
    cycle(0, 0, 0, 0, 0);

    // Drain and wrap: ID always ready, IF holds its PC until accepted.
    pc = 32'd20; pushed = 0;
    for (int k = 0; k < 30 && pushed < 6; k++) begin
      cycle(1, pc, 32'hA000_0000 + (pc >> 2) - 32'd1, 1, 0);
      if (accepted) begin pc += 32'd4; pushed++; end
    end
    chk("wrap_pushes", 64'(pushed), 64'(6));
    drain();

    // Simultaneous push/pop at count=2.
    cycle(1, 32'h100, 32'hB000_0000, 0, 0);
    cycle(1, 32'h104, 32'hB000_0001, 0, 0);
    cycle(1, 32'h108, 32'hB000_0002, 1, 0);
    cycle(0, 0, 0, 0, 0);
    chk("pp_count", 64'(count), 64'(2));
    chk("pp_head",  64'(id_pc), 64'(32'h104));
    drain();

    // Flush with count=3 and a simultaneous pair that must be dropped.
    for (int i = 0; i < 3; i++) cycle(1, 32'h200 + 32'(4*i), 32'hC000_0000 + 32'(i), 0, 0);
    cycle(1, 32'h999, 32'hDEAD_BEEF, 1, 1);
    cycle(1, 32'h40, 32'hC000_0040, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("post_flush_head", 64'(id_pc), 64'(32'h40));
    drain();

    // Empty pops are ignored; a following push lands at the head.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h300, 32'hE000_0000, 0, 0);
    cycle(1, 32'h304, 32'hE000_0001, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    chk("after_empty_pop", 64'(id_pc), 64'(32'h304));
    drain();

    // Asynchronous reset mid-traffic at count=3.
    for (int i = 0; i < 3; i++) cycle(1, 32'h400 + 32'(4*i), 32'hF000_0000 + 32'(i), 0, 0);
    @(negedge clk);
    if_valid = 0; id_ready = 0;
    @(posedge clk);
    chk("pre_rst_count", 64'(count), 64'(3));
    #2 rst = 1'b0;
    #1;
    chk("arst_count",  64'(count),     64'(0));
    chk("arst_valid",  64'(id_valid),  64'(0));
    chk("arst_instr",  64'(id_instr),  64'(0));
    chk("arst_freeze", 64'(if_freeze), 64'(0));
    sb.delete();
    @(negedge clk); rst = 1'b1;
    cycle(1, 32'h500, 32'h1234_5678, 0, 0);
    cycle(0, 0, 0, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction prefetch queue between the IF stage and the ID stage.
- Accepts one {PC, Instruction} pair per cycle from IF and presents the oldest pair to ID with a valid/ready handshake.
- Asserts a freeze back to IF when the queue is full, so IF and ID are decoupled across ID hazard stalls.
- A taken branch flushes every queued entry.

Parameters:
- DATA_LEN, 32, width of the PC and instruction fields.
- DEPTH, 4, number of queue entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), localparam for pointer width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- flush  input  1  Branch_taken from EXE; empties the queue.
- if_valid  input  1  IF presents a fetched pair this cycle.
- if_pc  input  DATA_LEN  PC value produced by IF (already PC+4).
- if_instr  input  DATA_LEN  Instruction produced by IF.
- if_freeze  output  1  freeze to IF; equals full.
- id_ready  input  1  ID consumes the head entry this cycle (low during hazard stall).
- id_valid  output  1  head entry is valid.
- id_pc  output  DATA_LEN  head PC; 0 when empty.
- id_instr  output  DATA_LEN  head instruction; 0 when empty.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Storage contents are don't-care. Outputs: id_valid=0, id_pc=0, id_instr=0, if_freeze=0.
- Storage: DEPTH x (2*DATA_LEN) register array, written at wr_ptr, read at rd_ptr. Pointers wrap modulo DEPTH by natural PTR_W overflow.
- Push fires when if_valid=1, full=0 and flush=0: write the entry and increment wr_ptr.
- Pop fires when id_ready=1, count!=0 and flush=0: increment rd_ptr.
- count update: +1 on push only, -1 on pop only, unchanged when both fire.
- Push with full=1 is ignored, even if a pop fires in the same cycle. if_freeze is a pure function of full, so IF holds its PC.
- id_ready with count=0 is ignored; no underflow.
- full = (count==DEPTH). empty = (count==0).
- id_valid = !empty, combinational from registered state.
- id_pc/id_instr = head entry when !empty, else 0, so ID sees a NOP (all-zero word).
- Latency: a pair pushed in cycle N appears at id_* in cycle N+1 if the queue was empty. There is no combinational bypass from if_* to id_*.
- Flush has priority over everything:
  - In the flush cycle, push and pop are suppressed.
  - Next edge: wr_ptr=0, rd_ptr=0, count=0.
  - A simultaneous if_valid pair is dropped; IF refetches from BranchAddr.
- The freeze input of IF is owned by this block. The global hazard freeze drives id_ready low and does not reach IF directly.
- Reset mid-operation: all entries are discarded immediately, regardless of flush or handshake inputs.

Decomposition:
- A shared pipeline package holds:
  - DATA_LEN default.
  - NOP_INSTR constant (32'h0).
  - Packed typedef fetch_entry_t {pc, instr}, also used by the ID stage register.
- One sub-module, fetch_queue_ctrl, is natural. It holds pointers, count, full/empty and push/pop/flush arbitration.
- The top level holds the storage array and output muxing.

Test Plan:
- Reset: rst=0 mid-traffic with count=3 -> count=0, id_valid=0, id_instr=0 and if_freeze=0 asynchronously, before the next edge.
- Fill: id_ready=0, push PC 4,8,12,16 with instrs A0..A3 -> count=4 and if_freeze=1 after the 4th edge. A 5th pair (PC 20) is ignored, and id_pc=4, id_instr=A0 throughout.
- Drain and wrap: from full, push 6 more pairs while id_ready=1 continuously -> id_pc sequence 4,8,12,16,20,... in order with no duplicates or gaps, and pointers wrap past DEPTH-1.
- Simultaneous push/pop at count=2 -> count stays 2, head advances one entry, and the new entry lands at the tail.
- Flush with count=3 and if_valid=1 the same cycle -> next cycle count=0, id_valid=0, id_pc=0. The dropped pair never appears, and the next pushed pair (PC 0x40) is at the head one cycle later.
- Empty pop: count=0, id_ready=1 for 3 cycles -> count stays 0, id_valid=0, and rd_ptr is unchanged.
